// File: rtl/trigger_capture_pkg.sv
// Shared types and constants for the trigger/capture stage behind the ADC decimator.
package trigger_capture_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } capture_state_t;

  localparam int unsigned SAMPLE_W = 8;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample memory: one write port, registered read port, single clock.
module sample_ram
  import trigger_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [AW-1:0]       i_raddr,
  output logic [SAMPLE_W-1:0] o_rdata
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [SAMPLE_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register resets; the array itself is left uninitialised.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trigger_capture.sv
// Circular capture of decimated ADC samples around a level/slope trigger, read back oldest-first.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                adc_dco,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                arm,
  input  logic                force_trig,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic [AW-1:0]       pretrig,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid,
  output logic                done,
  output logic [2:0]          state,
  output logic [AW-1:0]       trig_addr
);

  localparam logic [AW-1:0] MAX_PRE   = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_RD   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

  capture_state_t      r_state, w_next;
  logic [AW-1:0]       r_pre_n, r_wr_ptr, r_rd_ptr, r_trig_addr;
  logic [AW:0]         r_cnt;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_valid, r_rd_valid;

  logic [AW-1:0] w_pre_arm, w_trig_eff;
  logic [AW:0]   w_cnt_inc, w_post_target;
  logic          w_active, w_wr, w_rise, w_fall, w_trig, w_rd, w_last_rd, w_to_done;

  // Clamp stays meaningful if AW is overridden wider than log2(DEPTH).
  assign w_pre_arm     = (pretrig > MAX_PRE) ? MAX_PRE : pretrig;
  assign w_active      = (r_state == PREFILL) || (r_state == ARMED) || (r_state == POST);
  assign w_wr          = w_active && sample_valid && !arm;
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_post_target = DEPTH_CNT - {1'b0, r_pre_n};

  assign w_rise = r_prev_valid && (trig_slope == SLOPE_RISE) &&
                  (r_prev < trig_level) && (adc_data >= trig_level);
  assign w_fall = r_prev_valid && (trig_slope == SLOPE_FALL) &&
                  (r_prev > trig_level) && (adc_data <= trig_level);
  assign w_trig = w_wr && (r_state == ARMED) && (w_rise || w_fall || force_trig);

  assign w_rd       = (r_state == DONE) && rd_en && !arm;
  assign w_last_rd  = w_rd && (r_cnt == LAST_RD);
  assign w_to_done  = w_wr && (w_next == DONE);
  assign w_trig_eff = w_trig ? r_wr_ptr : r_trig_addr;

  always_comb begin
    w_next = r_state;
    if (arm) begin
      w_next = (w_pre_arm == '0) ? ARMED : PREFILL;
    end else begin
      unique case (r_state)
        PREFILL: if (w_wr && (w_cnt_inc == {1'b0, r_pre_n})) w_next = ARMED;
        ARMED:   if (w_trig) w_next = (w_post_target == CNT_ONE) ? DONE : POST;
        POST:    if (w_wr && (w_cnt_inc == w_post_target)) w_next = DONE;
        DONE:    if (w_last_rd) w_next = IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge adc_dco) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // r_cnt is reused: prefill count, post count, then read count once in DONE.
  always_ff @(posedge adc_dco) begin
    if (rst) begin
      r_pre_n      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_trig_addr  <= '0;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (arm) begin
        r_pre_n      <= w_pre_arm;
        r_cnt        <= '0;
        r_prev_valid <= 1'b0;
      end else begin
        if (w_wr) begin
          r_wr_ptr     <= r_wr_ptr + 1'b1;
          r_prev       <= adc_data;
          r_prev_valid <= 1'b1;
        end
        if (w_trig) r_trig_addr <= r_wr_ptr;
        if (w_to_done) begin
          r_cnt    <= '0;
          r_rd_ptr <= w_trig_eff - r_pre_n;
        end else if (w_trig) begin
          r_cnt <= CNT_ONE;
        end else if (w_wr || w_rd) begin
          r_cnt <= w_cnt_inc;
        end
        if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  sample_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (adc_dco),
    .i_rst   (rst),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (adc_data),
    .i_re    (w_rd),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign rd_valid  = r_rd_valid;
  assign done      = (r_state == DONE);
  assign state     = r_state;
  assign trig_addr = r_trig_addr;

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Downstream stage of the ADC acquisition block: consumes its decimated 8-bit samples, qualified by the one-cycle decimation strobe. Keeps a circular sample memory running, detects a level/slope trigger after a programmable pre-trigger fill, and captures a full record around the trigger. It then lets the host read that record out oldest-first.

## Interface
Parameters:
- DEPTH, 1024: record length in samples; power of two, ≥ 4.
- AW, $clog2(DEPTH): address / count width.

Ports:
- adc_dco  in  1  sample clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- sample_valid  in  1  one-cycle strobe from the decimation stage; adc_data is valid when it is high.
- adc_data  in  8  unsigned sample.
- arm  in  1  pulse; starts a new capture.
- force_trig  in  1  level; forces a trigger while armed.
- trig_level  in  8  unsigned trigger threshold.
- trig_slope  in  1  0 = rising, 1 = falling.
- pretrig  in  AW  number of samples kept before the trigger.
- rd_en  in  1  read-strobe for the next record sample.
- rd_data  out  8  record sample.
- rd_valid  out  1  rd_data is valid this cycle.
- done  out  1  record complete and readable.
- state  out  3  current FSM state (debug).
- trig_addr  out  AW  memory address of the trigger sample.

## Operation
- FSM states and codes: IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4.
- arm in any state:
  - Latches pretrig as pre_n; pre_n = min(pretrig, DEPTH-1).
  - Clears the sample counter, prev_valid and done.
  - Goes to PREFILL, or straight to ARMED if pre_n = 0.
  - arm wins over every other same-cycle event, including rst=0 reads.
- While in PREFILL, ARMED or POST, each sample_valid cycle:
  - writes adc_data to mem[wr_ptr];
  - increments wr_ptr, which wraps modulo DEPTH;
  - stores adc_data in prev and sets prev_valid.
- PREFILL: counts written samples. When the count reaches pre_n, go to ARMED.
- ARMED: a trigger occurs on a sample_valid cycle when one of these holds:
  - prev_valid, trig_slope=0, prev < trig_level and adc_data ≥ trig_level;
  - prev_valid, trig_slope=1, prev > trig_level and adc_data ≤ trig_level;
  - force_trig is high.
- On a trigger:
  - the sample is still written;
  - trig_addr ← wr_ptr (pre-increment);
  - the post count is set to 1;
  - go to POST.
- The first sample after arm cannot edge-trigger, because prev_valid is 0 at that point.
- POST: counts written samples, trigger sample included. At DEPTH − pre_n samples, go to DONE and assert done.
- DONE:
  - writes stop;
  - rd_ptr starts at (trig_addr − pre_n) mod DEPTH;
  - each rd_en cycle reads mem[rd_ptr] and increments rd_ptr modulo DEPTH;
  - after the DEPTH-th read, go to IDLE and clear done.
- rd_en is ignored outside DONE. sample_valid is ignored in IDLE and DONE.
- All comparisons are unsigned 8-bit. Counters are AW+1 bits so that a count of DEPTH is representable.

## Timing
- Reset values:
  - state=IDLE, done=0, rd_valid=0, rd_data=0, trig_addr=0;
  - wr_ptr=0, rd_ptr=0, prev_valid=0.
  - Memory contents are not reset.
- Write occurs in the same edge as sample_valid. State changes are registered, taking effect the edge after the qualifying sample.
- Read latency is 1 cycle: rd_en at cycle n gives rd_data/rd_valid at n+1. rd_valid is a single-cycle pulse per rd_en.
- On the DEPTH-th read, the state is IDLE at n+1, and that read's rd_valid still fires at n+1.
- rst mid-capture or mid-read:
  - returns to reset values on the next edge;
  - pending read data is dropped (rd_valid=0).
- done rises the edge after the last POST sample is written.

## Structure
- Package trigger_capture_pkg holds:
  - state enum capture_state_t (IDLE..DONE, 3 bits);
  - SAMPLE_W = 8;
  - slope constants SLOPE_RISE = 0 and SLOPE_FALL = 1.
- Sub-module sample_ram: simple dual-port, DEPTH×8, one write port, registered read port, single clock, no reset on storage.
- The FSM, trigger comparator, counters and read pointer live in trigger_capture.

## Test plan
- Reset → state=0, done=0, rd_valid=0, rd_data=0, trig_addr=0. rd_en pulses while IDLE produce no rd_valid.
- DEPTH=16, pretrig=4, ramp samples 0,1,2,… on every strobe, trig_level=10, rising; arm:
  - trigger on sample 10;
  - done after sample 21;
  - 16 reads return 6..21 in order;
  - then state=IDLE.
- Falling slope, level=0x80, samples 0xFF,0x90,0x80 → trigger on 0x80. Samples 0x70,0x60 do not re-trigger.
- First sample after arm ≥ level with no prior sample → no trigger. force_trig=1 while ARMED → trigger on the next strobe.
- pretrig=0 → arm goes straight to ARMED. pretrig=DEPTH+3 truncates to 3 → clamped to 3. rst asserted mid-POST → reset values, the next arm captures correctly.
- sample_valid every 3rd cycle → counters advance only on strobes. arm asserted in DONE mid-read → reads stop, new capture starts.
